// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the controller's RED/GREEN/YELLOW lamp lines.
// Checks lamp legality, phase order and phase duration, and counts completed light cycles.
module traffic_light_monitor #(
  parameter int PHASE_LEN = 10,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             green,
  input  logic             yellow,
  input  logic             clear_err,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             err_onehot,
  output logic             err_order,
  output logic             err_duration,
  output logic [2:0]       err_sticky,
  output logic [CNT_W-1:0] cycles_done
);

  typedef enum logic [1:0] {
    PH_RED    = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_INV    = 2'b11
  } phase_t;

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] RUN_REQ = CNT_W'(PHASE_LEN);

  // Registered state
  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             flagged_q, flagged_d;
  logic             inv_q, inv_d;
  logic             onehot_q, onehot_d;
  logic             order_q, order_d;
  logic             dur_q, dur_d;
  logic [2:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  phase_t cur;
  logic   changed;

  function automatic logic legal_edge(input phase_t from, input phase_t to);
    return (from == PH_RED    && to == PH_GREEN)  ||
           (from == PH_GREEN  && to == PH_YELLOW) ||
           (from == PH_YELLOW && to == PH_RED);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cur = PH_INV;
    unique case ({red, green, yellow})
      3'b100:  cur = PH_RED;
      3'b010:  cur = PH_GREEN;
      3'b001:  cur = PH_YELLOW;
      default: cur = PH_INV;
    endcase
    changed = (cur != phase_q);

    state_d   = state_q;
    phase_d   = cur;
    flagged_d = flagged_q;
    inv_d     = (cur == PH_INV);
    onehot_d  = 1'b0;
    order_d   = 1'b0;
    dur_d     = 1'b0;
    cycles_d  = cycles_q;

    if (changed)                 run_len_d = CNT_W'(1);
    else if (run_len_q != RUN_MAX) run_len_d = run_len_q + CNT_W'(1);
    else                         run_len_d = run_len_q;

    if (cur == PH_INV) begin
      // Pulse only on entry into an invalid run; reset is not counted as a sample.
      onehot_d  = ~inv_q;
      state_d   = ST_ACQUIRE;
      flagged_d = 1'b0;
    end else if (changed) begin
      flagged_d = 1'b0;
      if (phase_q != PH_INV) begin
        if (state_q == ST_ACQUIRE) begin
          if (legal_edge(phase_q, cur)) state_d = ST_LOCKED;
        end else if (legal_edge(phase_q, cur)) begin
          dur_d = (run_len_q != RUN_REQ) && !flagged_q;
          if (phase_q == PH_YELLOW) cycles_d = cycles_q + CNT_W'(1);
        end else begin
          order_d = 1'b1;
          state_d = ST_ACQUIRE;
        end
      end
    end else if (state_q == ST_LOCKED && run_len_q == RUN_REQ && !flagged_q) begin
      // Phase held past its slot: flag now, once, and suppress the check at the change.
      dur_d     = 1'b1;
      flagged_d = 1'b1;
    end

    // Set wins over clear.
    sticky_d = (sticky_q & {3{~clear_err}}) | {dur_d, order_d, onehot_d};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ACQUIRE;
      phase_q   <= PH_INV;
      run_len_q <= '0;
      flagged_q <= 1'b0;
      inv_q     <= 1'b0;
      onehot_q  <= 1'b0;
      order_q   <= 1'b0;
      dur_q     <= 1'b0;
      sticky_q  <= 3'b000;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      run_len_q <= run_len_d;
      flagged_q <= flagged_d;
      inv_q     <= inv_d;
      onehot_q  <= onehot_d;
      order_q   <= order_d;
      dur_q     <= dur_d;
      sticky_q  <= sticky_d;
      cycles_q  <= cycles_d;
    end
  end

  assign phase        = phase_q;
  assign locked       = (state_q == ST_LOCKED);
  assign err_onehot   = onehot_q;
  assign err_order    = order_q;
  assign err_duration = dur_q;
  assign err_sticky   = sticky_q;
  assign cycles_done  = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with PHASE_LEN=10, CNT_W=8.
// Each scenario task drives lamp patterns and compares outputs against hand-computed values.
module tb_traffic_light_monitor;

  localparam int PHASE_LEN = 10;
  localparam int CNT_W     = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             red, green, yellow, clear_err;
  logic [1:0]       phase;
  logic             locked, err_onehot, err_order, err_duration;
  logic [2:0]       err_sticky;
  logic [CNT_W-1:0] cycles_done;

  int errors = 0;
  int checks = 0;
  int n_onehot, n_order, n_dur;

  traffic_light_monitor #(.PHASE_LEN(PHASE_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .red(red), .green(green), .yellow(yellow),
    .clear_err(clear_err), .phase(phase), .locked(locked),
    .err_onehot(err_onehot), .err_order(err_order), .err_duration(err_duration),
    .err_sticky(err_sticky), .cycles_done(cycles_done)
  );

  always #5 clk = ~clk;

  // One sample: drive lamps, take the edge, settle 1 time unit, tally pulses.
  task automatic step(input logic r, input logic g, input logic y, input logic clr);
    red = r; green = g; yellow = y; clear_err = clr;
    @(posedge clk);
    #1;
    n_onehot += int'(err_onehot);
    n_order  += int'(err_order);
    n_dur    += int'(err_duration);
  endtask

  task automatic run(input logic r, input logic g, input logic y, input int n);
    for (int i = 0; i < n; i++) step(r, g, y, 1'b0);
  endtask

  task automatic clear_tally();
    n_onehot = 0; n_order = 0; n_dur = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    checks++;
    if (phase !== 2'b11 || locked !== 1'b0 || err_sticky !== 3'b000 || cycles_done !== '0 ||
        err_onehot !== 1'b0 || err_order !== 1'b0 || err_duration !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: phase=%b locked=%b sticky=%b cycles=%0d pulses=%b%b%b, want 11 0 000 0 000",
               phase, locked, err_sticky, cycles_done, err_onehot, err_order, err_duration);
    end
  endtask

  task automatic test_normal();
    clear_tally();
    run(1'b1, 1'b0, 1'b0, PHASE_LEN);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL lock_on_rg: locked=%b want 1", locked);
    end
    run(1'b0, 1'b1, 1'b0, PHASE_LEN - 1);
    run(1'b0, 1'b0, 1'b1, PHASE_LEN);
    for (int k = 0; k < 2; k++) begin
      run(1'b1, 1'b0, 1'b0, PHASE_LEN);
      run(1'b0, 1'b1, 1'b0, PHASE_LEN);
      run(1'b0, 1'b0, 1'b1, PHASE_LEN);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cycles_done !== 8'd3) begin
      errors++; $display("FAIL cycles_done: got %0d want 3", cycles_done);
    end
    checks++;
    if (phase !== 2'b00) begin
      errors++; $display("FAIL phase_red: got %b want 00", phase);
    end
    checks++;
    if (n_onehot + n_order + n_dur !== 0 || err_sticky !== 3'b000) begin
      errors++; $display("FAIL clean_run: pulses=%0d sticky=%b want 0 000", n_onehot + n_order + n_dur, err_sticky);
    end
  endtask

  task automatic test_short_phase();
    run(1'b1, 1'b0, 1'b0, PHASE_LEN - 1);
    clear_tally();
    run(1'b0, 1'b1, 1'b0, 7);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (err_duration !== 1'b1 || n_dur !== 1) begin
      errors++; $display("FAIL short_green: dur=%b count=%0d want 1 1", err_duration, n_dur);
    end
    checks++;
    if (err_sticky !== 3'b100 || phase !== 2'b10) begin
      errors++; $display("FAIL short_sticky: sticky=%b phase=%b want 100 10", err_sticky, phase);
    end
    run(1'b0, 1'b0, 1'b1, PHASE_LEN - 1);
  endtask

  task automatic test_stuck_phase();
    clear_tally();
    run(1'b1, 1'b0, 1'b0, PHASE_LEN);
    checks++;
    if (n_dur !== 0) begin
      errors++; $display("FAIL stuck_early: count=%0d want 0", n_dur);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (err_duration !== 1'b1) begin
      errors++; $display("FAIL stuck_pulse: dur=%b want 1", err_duration);
    end
    run(1'b1, 1'b0, 1'b0, 4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (n_dur !== 1 || err_duration !== 1'b0 || locked !== 1'b1) begin
      errors++; $display("FAIL stuck_once: count=%0d dur=%b locked=%b want 1 0 1", n_dur, err_duration, locked);
    end
    run(1'b0, 1'b1, 1'b0, PHASE_LEN - 1);
    run(1'b0, 1'b0, 1'b1, PHASE_LEN);
  endtask

  task automatic test_order();
    clear_tally();
    run(1'b1, 1'b0, 1'b0, PHASE_LEN);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (err_order !== 1'b1 || locked !== 1'b0 || err_duration !== 1'b0) begin
      errors++; $display("FAIL order_ry: order=%b locked=%b dur=%b want 1 0 0", err_order, locked, err_duration);
    end
    checks++;
    if (err_sticky !== 3'b110) begin
      errors++; $display("FAIL order_sticky: sticky=%b want 110", err_sticky);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1 || n_order !== 1) begin
      errors++; $display("FAIL relock: locked=%b orders=%0d want 1 1", locked, n_order);
    end
  endtask

  task automatic test_onehot();
    int bad_phase;
    clear_tally();
    bad_phase = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (phase !== 2'b11) bad_phase++;
    end
    checks++;
    if (bad_phase !== 0 || n_onehot !== 1 || locked !== 1'b0) begin
      errors++; $display("FAIL onehot_run: badphase=%0d pulses=%0d locked=%b want 0 1 0", bad_phase, n_onehot, locked);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_order !== 0 || err_sticky !== 3'b111) begin
      errors++; $display("FAIL onehot_exit: orders=%0d sticky=%b want 0 111", n_order, err_sticky);
    end
  endtask

  task automatic test_clear();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_sticky !== 3'b000) begin
      errors++; $display("FAIL clear_all: sticky=%b want 000", err_sticky);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (err_sticky !== 3'b001 || err_onehot !== 1'b1) begin
      errors++; $display("FAIL set_wins: sticky=%b onehot=%b want 001 1", err_sticky, err_onehot);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_sticky !== 3'b000) begin
      errors++; $display("FAIL clear_alone: sticky=%b want 000", err_sticky);
    end
  endtask

  task automatic test_mid_reset();
    run(1'b1, 1'b0, 1'b0, PHASE_LEN);
    run(1'b0, 1'b1, 1'b0, 3);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    checks++;
    if (phase !== 2'b11 || locked !== 1'b0 || err_duration !== 1'b0 || err_order !== 1'b0 ||
        cycles_done !== '0 || err_sticky !== 3'b000) begin
      errors++; $display("FAIL mid_reset: phase=%b locked=%b dur=%b cycles=%0d sticky=%b want 11 0 0 0 000",
                         phase, locked, err_duration, cycles_done, err_sticky);
    end
  endtask

  initial begin
    reset = 1'b0; red = 1'b0; green = 1'b0; yellow = 1'b0; clear_err = 1'b0;
    clear_tally();
    test_reset();
    test_normal();
    test_short_phase();
    test_stuck_phase();
    test_order();
    test_onehot();
    test_clear();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
